spi_slave: RTL

- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) for the far end of the team's SPI master link.
- Oversamples the external sclk, ss_n and mosi on the system clock. Shifts a received word into rx_data and shifts a preloaded word out on miso.
- Sits between the SPI pins and a local register/FIFO client, using a valid/ready handshake for TX and a strobe for RX.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_edge_sync.sv | 39 +++
 rtl/spi_slave.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI responder.
//   spi_state_t : frame FSM states (IDLE, SHIFT)
//   SPI_CPOL/SPI_CPHA : the only supported mode (mode 0)
//   SPI_DATA_W  : default frame word width
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  localparam logic SPI_CPOL   = 1'b0;
  localparam logic SPI_CPHA   = 1'b0;
  localparam int   SPI_DATA_W = 8;

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: multi-flop synchronizer for one asynchronous bit plus an
// edge detector on the synchronized value.
//   clk, rst : system clock, async active-high reset
//   pin      : asynchronous input
//   sync     : synchronized level
//   rise     : one-cycle pulse on a 0->1 transition of sync
//   fall     : one-cycle pulse on a 1->0 transition of sync
module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus one history flop. Resetting to the idle level
  // of the line keeps a spurious edge from appearing after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder, MSB first, oversampled on clk.
//   clk, rst     : system clock (>= 8x sclk), async active-high reset
//   sclk, ss_n   : SPI clock and active-low select (asynchronous)
//   mosi, miso   : SPI data in / out
//   tx_data, tx_valid, tx_ready : write port of the TX holding register
//   rx_data, rx_valid           : last received word and its update strobe
//   busy        : frame in progress
//   tx_underrun : pulse, a word load found the holding register empty
//   frame_abort : pulse, select released in the middle of a word
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_state_t state, state_next;
  logic do_load, do_shift, do_sample, do_end;

  logic [DATA_W-1:0] tx_shift, hold, rx_shift;
  logic              hold_full, word_done, rx_pend;
  logic [CNT_W-1:0]  bit_cnt;
  logic              tx_write;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .pin(sclk), .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss (
    .clk(clk), .rst(rst), .pin(ss_n), .sync(ss_s), .rise(ss_rise), .fall(ss_fall)
  );
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .pin(mosi), .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Only some of the synchronizer outputs matter here.
  assign unused_edges = ^{sclk_s, ss_s, mosi_rise, mosi_fall};

  assign tx_ready = ~hold_full;
  assign tx_write = tx_valid & ~hold_full;

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and per-cycle datapath commands. Select release wins over
  // any sclk edge in the same cycle; sclk edges are ignored outside a frame.
  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    do_sample  = 1'b0;
    do_end     = 1'b0;
    busy       = 1'b0;
    miso       = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_next = SHIFT;
          do_load    = 1'b1;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        miso = tx_shift[DATA_W-1];
        if (ss_rise) begin
          state_next = IDLE;
          do_end     = 1'b1;
        end else begin
          do_sample = sclk_rise;
          if (sclk_fall) begin
            do_load  = word_done;
            do_shift = ~word_done;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath. The load decision uses the holding state from before any
  // same-cycle write, so a write racing a load goes to the next word.
  // rx_valid trails the rx_data update by one cycle via rx_pend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift    <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_pend     <= 1'b0;
      rx_valid    <= 1'b0;
      bit_cnt     <= '0;
      word_done   <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= rx_pend;
      rx_pend     <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;

      if (tx_write) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end

      if (do_load) begin
        word_done <= 1'b0;
        if (hold_full) begin
          tx_shift  <= hold;
          hold_full <= 1'b0;
        end else begin
          tx_shift    <= '0;
          tx_underrun <= 1'b1;
        end
      end

      if (do_shift) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};

      if (do_sample) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
        if (bit_cnt == LAST_BIT) begin
          rx_data   <= {rx_shift[DATA_W-2:0], mosi_s};
          rx_pend   <= 1'b1;
          bit_cnt   <= '0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end

      // Releasing select mid-word throws the partial word away.
      if (do_end) begin
        if (bit_cnt != '0) frame_abort <= 1'b1;
        bit_cnt   <= '0;
        word_done <= 1'b0;
        rx_shift  <= '0;
      end
    end
  end

endmodule
